// File: rtl/fft_pair_feeder.sv
// Frame buffer that collects 2*HALF serial samples, then issues radix-2 butterfly
// operand pairs (x[k], x[k+HALF]). Optional FEED_SCALE_EN halves each stored sample.
module fft_pair_feeder #(
  parameter int N        = 4,
  parameter int HALF     = 4,
  parameter int LOG_HALF = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [(2**N)-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [(2**N)-1:0]     out_a,
  output logic [(2**N)-1:0]     out_b,
  output logic [LOG_HALF-1:0]   out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int W = 2**N;

  // HALF is a power of two, so the last fill slot and the last pair index are all-ones.
  localparam logic [LOG_HALF:0]   FILL_LAST = {(LOG_HALF+1){1'b1}};
  localparam logic [LOG_HALF:0]   FILL_ONE  = (LOG_HALF+1)'(1);
  localparam logic [LOG_HALF-1:0] PAIR_LAST = {LOG_HALF{1'b1}};
  localparam logic [LOG_HALF-1:0] PAIR_ONE  = LOG_HALF'(1);
  localparam logic [LOG_HALF:0]   MEM_A0    = {(LOG_HALF+1){1'b0}};
  localparam logic [LOG_HALF:0]   MEM_B0    = {1'b1, {LOG_HALF{1'b0}}};

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              state_r;
  logic [LOG_HALF:0]   fill_cnt_r;
  logic [LOG_HALF-1:0] pair_cnt_r;
  logic [W-1:0]        mem_r [2*HALF];
  logic [W-1:0]        out_a_r;
  logic [W-1:0]        out_b_r;
  logic [LOG_HALF-1:0] out_idx_r;
  logic                out_valid_r;
  logic                frame_done_r;

  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                fill_last_s;
  logic                pair_last_s;
  logic [LOG_HALF-1:0] pair_nxt_s;
  logic [W-1:0]        store_s;

  function automatic logic [W-1:0] scale_word(input logic [W-1:0] d);
`ifdef FEED_SCALE_EN
    return {d[W-1], d[W-1:1]};
`else
    return d;
`endif
  endfunction

  // Handshake decode and next-pair index.
  always_comb begin
    in_xfer_s   = in_valid && (state_r == FILL);
    out_xfer_s  = out_valid_r && out_ready;
    fill_last_s = (fill_cnt_r == FILL_LAST);
    pair_last_s = (pair_cnt_r == PAIR_LAST);
    pair_nxt_s  = pair_cnt_r + PAIR_ONE;
    store_s     = scale_word(in_data);
  end

  // Sample buffer write; an aborted cycle writes nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2*HALF; i++) mem_r[i] <= '0;
    end else if (!clr && in_xfer_s) begin
      mem_r[fill_cnt_r] <= store_s;
    end
  end

  // Fill/issue controller with registered pair outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FILL;
      fill_cnt_r   <= '0;
      pair_cnt_r   <= '0;
      out_a_r      <= '0;
      out_b_r      <= '0;
      out_idx_r    <= '0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (clr) begin
      state_r      <= FILL;
      fill_cnt_r   <= '0;
      pair_cnt_r   <= '0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (in_xfer_s) begin
            if (fill_last_s) begin
              // x[HALF] was stored earlier, so the first pair comes straight from the buffer.
              fill_cnt_r  <= '0;
              pair_cnt_r  <= '0;
              state_r     <= ISSUE;
              out_a_r     <= mem_r[MEM_A0];
              out_b_r     <= mem_r[MEM_B0];
              out_idx_r   <= '0;
              out_valid_r <= 1'b1;
            end else begin
              fill_cnt_r <= fill_cnt_r + FILL_ONE;
            end
          end
        end
        ISSUE: begin
          if (out_xfer_s) begin
            if (pair_last_s) begin
              pair_cnt_r   <= '0;
              out_valid_r  <= 1'b0;
              frame_done_r <= 1'b1;
              state_r      <= FILL;
            end else begin
              pair_cnt_r <= pair_nxt_s;
              out_a_r    <= mem_r[{1'b0, pair_nxt_s}];
              out_b_r    <= mem_r[{1'b1, pair_nxt_s}];
              out_idx_r  <= pair_nxt_s;
            end
          end
        end
        default: begin
          state_r     <= FILL;
          fill_cnt_r  <= '0;
          pair_cnt_r  <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == FILL);
  assign out_a      = out_a_r;
  assign out_b      = out_b_r;
  assign out_idx    = out_idx_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Scoreboard bench for fft_pair_feeder: a frame-level model turns accepted samples into
// expected pairs; a negedge monitor compares them and the handshake flags.
module tb_fft_pair_feeder;

  localparam int N        = 4;
  localparam int W        = 2**N;
  localparam int HALF     = 4;
  localparam int LOG_HALF = 2;

  typedef struct {
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic [LOG_HALF-1:0] idx;
  } pair_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                clr;
  logic [W-1:0]        in_data;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        out_a;
  logic [W-1:0]        out_b;
  logic [LOG_HALF-1:0] out_idx;
  logic                out_valid;
  logic                out_ready;
  logic                frame_done;

  int           checks = 0;
  int           errors = 0;
  pair_t        exp_q[$];
  logic [W-1:0] frame_q[$];
  bit           fd_exp = 1'b0;

  fft_pair_feeder #(.N(N), .HALF(HALF), .LOG_HALF(LOG_HALF)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_store(input logic [W-1:0] s);
`ifdef FEED_SCALE_EN
    logic signed [W-1:0] v;
    v = s;
    return v >>> 1;
`else
    return s;
`endif
  endfunction

  // Frame model: once 2*HALF samples are in, the butterfly pairs are x[k] and x[k+HALF].
  task automatic model_accept(input logic [W-1:0] s);
    pair_t p;
    frame_q.push_back(model_store(s));
    if (frame_q.size() == 2*HALF) begin
      for (int k = 0; k < HALF; k++) begin
        p.a   = frame_q[k];
        p.b   = frame_q[k+HALF];
        p.idx = LOG_HALF'(k);
        exp_q.push_back(p);
      end
      frame_q.delete();
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted s.
  task automatic send(input logic [W-1:0] s);
    int t = 0;
    in_data  = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for sample %0h", s);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      model_accept(s);
    end
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      t++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pairs still pending", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: flags against model occupancy, presented pair against queue head.
  always @(negedge clk) begin
    if (!rst) begin
      fd_exp = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      fd_exp = 1'b0;
      if (out_valid && exp_q.size() != 0) begin
        chk("out_a", 32'(out_a), 32'(exp_q[0].a));
        chk("out_b", 32'(out_b), 32'(exp_q[0].b));
        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
        if (out_ready && !clr) begin
          if (exp_q[0].idx == LOG_HALF'(HALF-1)) fd_exp = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming frame with no backpressure.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(W'(i));
    in_valid = 1'b0;
    drain(1'b0);

    // Backpressure on pair 1 while a stray 0x7FFF is offered during issue.
    out_ready = 1'b0;
    for (int i = 9; i <= 16; i++) send(W'(i));
    in_data = 16'h7FFF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(1'b0);

    // Asynchronous reset mid-fill, then a clean frame.
    for (int i = 20; i <= 24; i++) send(W'(i));
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_a", 32'(out_a), 32'd0);
    chk("midrst_out_b", 32'(out_b), 32'd0);
    chk("midrst_out_idx", 32'(out_idx), 32'd0);
    frame_q.delete();
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 20; i <= 27; i++) send(W'(i));
    in_valid = 1'b0;
    drain(1'b0);

    // Abort coincident with acceptance of pair 1.
    out_ready = 1'b1;
    for (int i = 30; i <= 37; i++) send(W'(i));
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    frame_q.delete();
    for (int i = 40; i <= 47; i++) send(W'(i));
    in_valid = 1'b0;
    drain(1'b0);

    // Sign/magnitude corner samples through the optional scaler.
    send(16'hFFFD); send(16'h0008); send(16'h7FFF); send(16'h8000);
    send(16'h0001); send(16'hFFFF); send(16'h1234); send(16'h0000);
    in_valid = 1'b0;
    drain(1'b0);

    // Randomized frames with idle gaps and random backpressure.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 2*HALF; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        send(W'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
      end
      in_valid = 1'b0;
      drain(1'b1);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
